stream_checker: RTL and testbench
=================================

Name: stream_checker

Overview:
- AXI4-Stream sink and pattern checker; receive-side counterpart of the stream_master generator.
- Sits on the m_axis output of the HDLC wrapper (or any AXIS loopback) in benches and on-chip BIST.
- Consumes packets and checks data against the programmed start/increment/fix pattern, packet length and tdest.
- Reports per-class error counters and a pass/done status.

Parameters:
- TBYTE_NUM, 1, data width in bytes; tdata is TBYTE_NUM*8 bits, tkeep is TBYTE_NUM bits.
- CNT_WIDTH, 32, width of length, count and timeout fields.
- TIMEOUT, 100000, idle clk cycles in RUN with no accepted beat before aborting.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- exp_dest  in  5  expected tdest.
- pkt_len  in  CNT_WIDTH  expected beats per packet.
- trans_len  in  CNT_WIDTH  expected packets per run.
- start_from  in  TBYTE_NUM*8  first beat value of each packet.
- inc  in  TBYTE_NUM*8  per-beat increment.
- fix  in  1  1 = every beat equals start_from.
- check_start  in  1  start pulse.
- check_busy  out  1  high in RUN.
- done  out  1  one-cycle pulse at end of run.
- pass  out  1  sticky: last run had zero errors and no timeout.
- timeout  out  1  sticky: last run aborted on idle timeout.
- s_axis_tdata  in  TBYTE_NUM*8  data.
- s_axis_tvalid  in  1  valid.
- s_axis_tready  out  1  ready.
- s_axis_tlast  in  1  end of packet.
- s_axis_tkeep  in  TBYTE_NUM  byte enables.
- s_axis_tid  in  5  ignored.
- s_axis_tdest  in  5  checked against exp_dest.
- pkt_cnt  out  CNT_WIDTH  packets received (tlast beats).
- beat_cnt  out  CNT_WIDTH  total beats accepted.
- data_err_cnt  out  CNT_WIDTH  beats with data or keep mismatch.
- len_err_cnt  out  CNT_WIDTH  packets with wrong beat count.
- dest_err_cnt  out  CNT_WIDTH  beats with tdest != exp_dest.

Behaviour:
- Reset:
  - All outputs are 0, state is IDLE, s_axis_tready is 0.
  - pass and timeout are cleared only by reset or check_start.
- States:
  - IDLE -> RUN on check_start.
    - Latches all config inputs.
    - Clears all counters, pass and timeout.
    - Sets the expected value to start_from.
    - If trans_len == 0, goes to DONE instead.
  - RUN -> DONE on acceptance of the tlast beat that makes pkt_cnt == trans_len, or on idle timeout.
  - DONE -> IDLE after one cycle.
    - done = 1 for that cycle.
    - pass = (all error counters == 0) && !timeout.
- check_start outside IDLE is ignored. Config changes outside IDLE have no effect.
- tready:
  - 1 throughout RUN, 0 in IDLE and DONE.
  - A beat is accepted when tvalid && tready; at most one beat per cycle.
- Per accepted beat:
  - beat_cnt++ and in-packet beat index++.
  - Data check:
    - For each lane k with tkeep[k] = 1, byte k of tdata must equal byte k of the expected value.
    - A non-last beat with tkeep != all ones is a data error.
    - At most one data_err increment per beat.
  - tdest != exp_dest increments dest_err_cnt.
  - If fix = 0, the next expected value is expected + inc, modulo 2^(8*TBYTE_NUM) (wraps silently).
- On a tlast beat:
  - pkt_cnt++.
  - If the in-packet beat count, including this beat, != pkt_len, len_err_cnt++ (once per packet, both short and long).
  - Resets the in-packet index and reloads the expected value to start_from.
- Timeout:
  - An idle counter increments every RUN cycle without an accepted beat and clears on each acceptance.
  - Reaching TIMEOUT sets timeout and goes to DONE.
  - pass = 0 after a timeout.
- Error and pkt/beat counters saturate at all ones.
- Registered outputs; counters update the cycle after acceptance.
- check_busy = 1 exactly in RUN.
- rstn low mid-run: immediate return to IDLE with all outputs reset; no done pulse.

Optional Feature:
- Macro: STREAM_CHECKER_BP_EN.
- Defined:
  - In RUN, s_axis_tready = lfsr[0] & lfsr[3] from a 16-bit Fibonacci LFSR (taps 16,14,13,11).
  - The LFSR is seeded to 16'hACE1 on reset and steps every cycle, giving roughly 25% ready duty.
  - Idle-timeout counting is unchanged; only accepted beats clear it.
- Undefined: tready = 1 throughout RUN, no LFSR logic.

Test Plan:
- Clean run: TBYTE_NUM = 1, pkt_len = 10, trans_len = 10, start_from = 8'h01, inc = 8'h01, fix = 0; drive 10 packets 01..0A. Required: done pulse, pass = 1, pkt_cnt = 10, beat_cnt = 100, all error counters 0.
- Data corruption: same config, flip beat 5 of packet 3 to 8'hFF. Required: data_err_cnt = 1, pass = 0, other error counters 0.
- Length errors: packet 2 has tlast at beat 9, packet 4 has tlast at beat 11. Required: len_err_cnt = 2; data check resyncs to 8'h01 on the next packet.
- Wrap and fix:
  - start_from = 8'hFE, inc = 8'h01, pkt_len = 4; drive FE FF 00 01. Required: no errors.
  - fix = 1, start_from = 8'h55; drive all beats 55. Required: pass = 1.
- Timeout and dest:
  - TIMEOUT = 50, stop the source after 3 packets of 10. Required: timeout = 1, done, pkt_cnt = 3, pass = 0.
  - Separate run with tdest = 1 vs exp_dest = 0 for one 10-beat packet. Required: dest_err_cnt = 10.
- Reset mid-run: assert rstn low during packet 2. Required: next cycle tready = 0, counters 0, check_busy = 0, no done pulse.

Source files
------------

// File: rtl/stream_checker.sv
// AXI4-Stream sink that checks packets against a start/increment/fix data pattern, packet length and tdest.
// Define STREAM_CHECKER_BP_EN to throttle s_axis_tready with a 16-bit LFSR (about 25% ready duty).
module stream_checker #(
    parameter int TBYTE_NUM = 1,
    parameter int CNT_WIDTH = 32,
    parameter int TIMEOUT   = 100000
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [4:0]             exp_dest,
    input  logic [CNT_WIDTH-1:0]   pkt_len,
    input  logic [CNT_WIDTH-1:0]   trans_len,
    input  logic [TBYTE_NUM*8-1:0] start_from,
    input  logic [TBYTE_NUM*8-1:0] inc,
    input  logic                   fix,
    input  logic                   check_start,
    output logic                   check_busy,
    output logic                   done,
    output logic                   pass,
    output logic                   timeout,
    input  logic [TBYTE_NUM*8-1:0] s_axis_tdata,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic                   s_axis_tlast,
    input  logic [TBYTE_NUM-1:0]   s_axis_tkeep,
    input  logic [4:0]             s_axis_tid,
    input  logic [4:0]             s_axis_tdest,
    output logic [CNT_WIDTH-1:0]   pkt_cnt,
    output logic [CNT_WIDTH-1:0]   beat_cnt,
    output logic [CNT_WIDTH-1:0]   data_err_cnt,
    output logic [CNT_WIDTH-1:0]   len_err_cnt,
    output logic [CNT_WIDTH-1:0]   dest_err_cnt
);

    localparam int DW = TBYTE_NUM * 8;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_C = CNT_WIDTH'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state_q, state_d;
    logic [4:0]             exp_dest_q, exp_dest_d;
    logic [CNT_WIDTH-1:0]   pkt_len_q, pkt_len_d;
    logic [CNT_WIDTH-1:0]   trans_len_q, trans_len_d;
    logic [DW-1:0]          start_from_q, start_from_d;
    logic [DW-1:0]          inc_q, inc_d;
    logic                   fix_q, fix_d;
    logic [DW-1:0]          expected_q, expected_d;
    logic [CNT_WIDTH-1:0]   idx_q, idx_d;
    logic [CNT_WIDTH-1:0]   idle_q, idle_d;
    logic [CNT_WIDTH-1:0]   pkt_cnt_q, pkt_cnt_d;
    logic [CNT_WIDTH-1:0]   beat_cnt_q, beat_cnt_d;
    logic [CNT_WIDTH-1:0]   data_err_q, data_err_d;
    logic [CNT_WIDTH-1:0]   len_err_q, len_err_d;
    logic [CNT_WIDTH-1:0]   dest_err_q, dest_err_d;
    logic                   pass_q, pass_d;
    logic                   timeout_q, timeout_d;
    logic                   accept;
    logic                   data_bad;
    logic                   unused_tid;

    assign unused_tid = ^s_axis_tid;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

`ifdef STREAM_CHECKER_BP_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR, taps 16,14,13,11; free-running so the ready pattern is repeatable from reset
    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    always_ff @(posedge clk) begin
        if (!rstn) lfsr_q <= 16'hACE1;
        else       lfsr_q <= lfsr_d;
    end

    assign s_axis_tready = (state_q == RUN) & lfsr_q[0] & lfsr_q[3];
`else
    assign s_axis_tready = (state_q == RUN);
`endif

    assign accept = s_axis_tvalid && s_axis_tready;

    always_comb begin
        data_bad = 1'b0;
        for (int k = 0; k < TBYTE_NUM; k++) begin
            if (s_axis_tkeep[k] && (s_axis_tdata[8*k +: 8] != expected_q[8*k +: 8]))
                data_bad = 1'b1;
        end
        if (!s_axis_tlast && (s_axis_tkeep != '1))
            data_bad = 1'b1;
    end

    always_comb begin
        state_d      = state_q;
        exp_dest_d   = exp_dest_q;
        pkt_len_d    = pkt_len_q;
        trans_len_d  = trans_len_q;
        start_from_d = start_from_q;
        inc_d        = inc_q;
        fix_d        = fix_q;
        expected_d   = expected_q;
        idx_d        = idx_q;
        idle_d       = idle_q;
        pkt_cnt_d    = pkt_cnt_q;
        beat_cnt_d   = beat_cnt_q;
        data_err_d   = data_err_q;
        len_err_d    = len_err_q;
        dest_err_d   = dest_err_q;
        pass_d       = pass_q;
        timeout_d    = timeout_q;

        case (state_q)
            IDLE: begin
                if (check_start) begin
                    exp_dest_d   = exp_dest;
                    pkt_len_d    = pkt_len;
                    trans_len_d  = trans_len;
                    start_from_d = start_from;
                    inc_d        = inc;
                    fix_d        = fix;
                    expected_d   = start_from;
                    idx_d        = '0;
                    idle_d       = '0;
                    pkt_cnt_d    = '0;
                    beat_cnt_d   = '0;
                    data_err_d   = '0;
                    len_err_d    = '0;
                    dest_err_d   = '0;
                    pass_d       = 1'b0;
                    timeout_d    = 1'b0;
                    state_d      = (trans_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    idle_d     = '0;
                    beat_cnt_d = sat_inc(beat_cnt_q);
                    if (data_bad)                   data_err_d = sat_inc(data_err_q);
                    if (s_axis_tdest != exp_dest_q) dest_err_d = sat_inc(dest_err_q);
                    if (s_axis_tlast) begin
                        pkt_cnt_d = sat_inc(pkt_cnt_q);
                        if ((idx_q + CNT_ONE) != pkt_len_q) len_err_d = sat_inc(len_err_q);
                        idx_d      = '0;
                        expected_d = start_from_q;
                        if (pkt_cnt_d == trans_len_q) state_d = DONE;
                    end else begin
                        idx_d = idx_q + CNT_ONE;
                        if (!fix_q) expected_d = expected_q + inc_q;
                    end
                end else begin
                    idle_d = idle_q + CNT_ONE;
                    if (idle_d >= TIMEOUT_C) begin
                        timeout_d = 1'b1;
                        state_d   = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Verdict is taken on entry to DONE so it is already valid alongside the done pulse
        if ((state_q != DONE) && (state_d == DONE))
            pass_d = (data_err_d == '0) && (len_err_d == '0) && (dest_err_d == '0) && !timeout_d;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= IDLE;
            exp_dest_q   <= '0;
            pkt_len_q    <= '0;
            trans_len_q  <= '0;
            start_from_q <= '0;
            inc_q        <= '0;
            fix_q        <= 1'b0;
            expected_q   <= '0;
            idx_q        <= '0;
            idle_q       <= '0;
            pkt_cnt_q    <= '0;
            beat_cnt_q   <= '0;
            data_err_q   <= '0;
            len_err_q    <= '0;
            dest_err_q   <= '0;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            exp_dest_q   <= exp_dest_d;
            pkt_len_q    <= pkt_len_d;
            trans_len_q  <= trans_len_d;
            start_from_q <= start_from_d;
            inc_q        <= inc_d;
            fix_q        <= fix_d;
            expected_q   <= expected_d;
            idx_q        <= idx_d;
            idle_q       <= idle_d;
            pkt_cnt_q    <= pkt_cnt_d;
            beat_cnt_q   <= beat_cnt_d;
            data_err_q   <= data_err_d;
            len_err_q    <= len_err_d;
            dest_err_q   <= dest_err_d;
            pass_q       <= pass_d;
            timeout_q    <= timeout_d;
        end
    end

    assign check_busy   = (state_q == RUN);
    assign done         = (state_q == DONE);
    assign pass         = pass_q;
    assign timeout      = timeout_q;
    assign pkt_cnt      = pkt_cnt_q;
    assign beat_cnt     = beat_cnt_q;
    assign data_err_cnt = data_err_q;
    assign len_err_cnt  = len_err_q;
    assign dest_err_cnt = dest_err_q;

endmodule

// File: tb/tb_stream_checker.sv
// Scoreboard bench for stream_checker: each run pushes its expected result summary,
// and the done-pulse monitor pops and compares it against the DUT counters and status.
module tb_stream_checker;

    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [4:0]    exp_dest = '0;
    logic [CW-1:0] pkt_len = '0;
    logic [CW-1:0] trans_len = '0;
    logic [7:0]    start_from = '0;
    logic [7:0]    inc = '0;
    logic          fix = 1'b0;
    logic          check_start = 1'b0;
    logic          check_busy, done, pass, timeout;
    logic [7:0]    s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          s_axis_tlast = 1'b0;
    logic [0:0]    s_axis_tkeep = 1'b1;
    logic [4:0]    s_axis_tid = '0;
    logic [4:0]    s_axis_tdest = '0;
    logic [CW-1:0] pkt_cnt, beat_cnt, data_err_cnt, len_err_cnt, dest_err_cnt;

    typedef struct {
        logic [CW-1:0] pkts;
        logic [CW-1:0] beats;
        logic [CW-1:0] derr;
        logic [CW-1:0] lerr;
        logic [CW-1:0] xerr;
        logic          pass;
        logic          tmo;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   done_count = 0;
    int   done_before = 0;
    int   runs_expected = 0;

    stream_checker #(.TBYTE_NUM(1), .CNT_WIDTH(CW), .TIMEOUT(50)) dut (
        .clk(clk), .rstn(rstn), .exp_dest(exp_dest), .pkt_len(pkt_len),
        .trans_len(trans_len), .start_from(start_from), .inc(inc), .fix(fix),
        .check_start(check_start), .check_busy(check_busy), .done(done),
        .pass(pass), .timeout(timeout), .s_axis_tdata(s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tid(s_axis_tid), .s_axis_tdest(s_axis_tdest),
        .pkt_cnt(pkt_cnt), .beat_cnt(beat_cnt), .data_err_cnt(data_err_cnt),
        .len_err_cnt(len_err_cnt), .dest_err_cnt(dest_err_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    function automatic exp_t make_exp(input int p, input int b, input int d, input int l, input int x,
                                      input logic ps, input logic t);
        exp_t e;
        e.pkts = CW'(p); e.beats = CW'(b); e.derr = CW'(d); e.lerr = CW'(l); e.xerr = CW'(x);
        e.pass = ps; e.tmo = t;
        return e;
    endfunction

    // Every done pulse retires the oldest expected run summary
    always @(posedge clk) begin
        #1;
        if (rstn && done) begin
            done_count++;
            if (sb_q.size() == 0) begin
                checkOutput("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                checkOutput("pkt_cnt", pkt_cnt, e.pkts);
                checkOutput("beat_cnt", beat_cnt, e.beats);
                checkOutput("data_err_cnt", data_err_cnt, e.derr);
                checkOutput("len_err_cnt", len_err_cnt, e.lerr);
                checkOutput("dest_err_cnt", dest_err_cnt, e.xerr);
                checkOutput("pass", pass, e.pass);
                checkOutput("timeout", timeout, e.tmo);
            end
        end
    end

    task automatic applyStimulus(input logic [4:0] dst, input int plen, input int tlen, input logic [7:0] sf,
                                 input logic [7:0] step, input logic fx, input bit push, input exp_t e);
        exp_dest = dst; pkt_len = CW'(plen); trans_len = CW'(tlen);
        start_from = sf; inc = step; fix = fx;
        done_before = done_count;
        if (push) begin
            sb_q.push_back(e);
            runs_expected++;
        end
        check_start = 1'b1;
        @(posedge clk); #1;
        check_start = 1'b0;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic last, input logic keep, input logic [4:0] dst);
        bit acc;
        acc = 1'b0;
        s_axis_tdata = d; s_axis_tlast = last; s_axis_tkeep = keep; s_axis_tdest = dst;
        s_axis_tvalid = 1'b1;
        for (int n = 0; n < 100 && !acc; n++) begin
            acc = s_axis_tready;
            @(posedge clk); #1;
        end
        if (!acc) checkOutput("beat_accept", 0, 1);
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
    endtask

    // bad_idx < 0 means no corrupted beat
    task automatic send_pkt(input int n, input logic [7:0] first, input logic [7:0] step,
                            input int bad_idx, input logic [4:0] dst);
        logic [7:0] v;
        v = first;
        for (int i = 0; i < n; i++) begin
            send_beat((i == bad_idx) ? 8'hFF : v, (i == n - 1), 1'b1, dst);
            v = v + step;
        end
    endtask

    task automatic wait_done(input int budget);
        int c;
        c = 0;
        while (done_count == done_before && c < budget) begin
            @(posedge clk); #1;
            c++;
        end
        if (done_count == done_before) checkOutput("done_wait", 0, 1);
        @(posedge clk); #1;
        checkOutput("done_pulse_width", done, 0);
        checkOutput("busy_after_done", check_busy, 0);
        checkOutput("tready_idle", s_axis_tready, 0);
    endtask

    initial begin
        exp_t none;
        none = make_exp(0, 0, 0, 0, 0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_tready", s_axis_tready, 0);
        checkOutput("rst_busy", check_busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_pass", pass, 0);
        checkOutput("rst_timeout", timeout, 0);
        checkOutput("rst_pkt_cnt", pkt_cnt, 0);
        checkOutput("rst_beat_cnt", beat_cnt, 0);
        checkOutput("rst_errs", {data_err_cnt, len_err_cnt} | {32'h0, dest_err_cnt}, 0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Clean run; a config change after start must not matter
        applyStimulus(5'd0, 10, 10, 8'h01, 8'h01, 1'b0, 1, make_exp(10, 100, 0, 0, 0, 1'b1, 1'b0));
        checkOutput("busy_in_run", check_busy, 1);
`ifndef STREAM_CHECKER_BP_EN
        checkOutput("tready_in_run", s_axis_tready, 1);
`endif
        pkt_len = 32'd5; start_from = 8'h80;
        for (int p = 0; p < 10; p++) send_pkt(10, 8'h01, 8'h01, -1, 5'd0);
        wait_done(200);
        checkOutput("pass_sticky", pass, 1);

        // Data corruption: beat 5 of packet 3
        applyStimulus(5'd0, 10, 10, 8'h01, 8'h01, 1'b0, 1, make_exp(10, 100, 1, 0, 0, 1'b0, 1'b0));
        for (int p = 1; p <= 10; p++) send_pkt(10, 8'h01, 8'h01, (p == 3) ? 4 : -1, 5'd0);
        wait_done(200);

        // Length errors: short packet 2, long packet 4; data resyncs afterwards
        applyStimulus(5'd0, 10, 10, 8'h01, 8'h01, 1'b0, 1, make_exp(10, 100, 0, 2, 0, 1'b0, 1'b0));
        for (int p = 1; p <= 10; p++) send_pkt((p == 2) ? 9 : (p == 4) ? 11 : 10, 8'h01, 8'h01, -1, 5'd0);
        wait_done(200);

        // Wrap through 8'hFF
        applyStimulus(5'd0, 4, 2, 8'hFE, 8'h01, 1'b0, 1, make_exp(2, 8, 0, 0, 0, 1'b1, 1'b0));
        for (int p = 0; p < 2; p++) send_pkt(4, 8'hFE, 8'h01, -1, 5'd0);
        wait_done(200);

        // Fixed pattern ignores inc
        applyStimulus(5'd0, 10, 2, 8'h55, 8'h01, 1'b1, 1, make_exp(2, 20, 0, 0, 0, 1'b1, 1'b0));
        for (int p = 0; p < 2; p++) send_pkt(10, 8'h55, 8'h00, -1, 5'd0);
        wait_done(200);

        // Keep handling: masked last lane is not checked, partial keep on a non-last beat is an error
        applyStimulus(5'd0, 3, 2, 8'h01, 8'h01, 1'b0, 1, make_exp(2, 6, 1, 0, 0, 1'b0, 1'b0));
        send_beat(8'h01, 1'b0, 1'b1, 5'd0);
        send_beat(8'h02, 1'b0, 1'b1, 5'd0);
        send_beat(8'hAA, 1'b1, 1'b0, 5'd0);
        send_beat(8'h01, 1'b0, 1'b0, 5'd0);
        send_beat(8'h02, 1'b0, 1'b1, 5'd0);
        send_beat(8'h03, 1'b1, 1'b1, 5'd0);
        wait_done(200);

        // Timeout after three of ten packets
        applyStimulus(5'd0, 10, 10, 8'h01, 8'h01, 1'b0, 1, make_exp(3, 30, 0, 0, 0, 1'b0, 1'b1));
        for (int p = 0; p < 3; p++) send_pkt(10, 8'h01, 8'h01, -1, 5'd0);
        wait_done(200);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("timeout_sticky", timeout, 1);

        // Wrong tdest on every beat
        applyStimulus(5'd0, 10, 1, 8'h01, 8'h01, 1'b0, 1, make_exp(1, 10, 0, 0, 10, 1'b0, 1'b0));
        send_pkt(10, 8'h01, 8'h01, -1, 5'd1);
        wait_done(200);

        // Zero-length transfer completes immediately
        applyStimulus(5'd0, 10, 0, 8'h01, 8'h01, 1'b0, 1, make_exp(0, 0, 0, 0, 0, 1'b1, 1'b0));
        wait_done(20);

        // Reset during packet 2: no done pulse, everything cleared
        applyStimulus(5'd0, 10, 10, 8'h01, 8'h01, 1'b0, 0, none);
        send_pkt(10, 8'h01, 8'h01, -1, 5'd0);
        for (int i = 0; i < 5; i++) send_beat(8'(i + 1), 1'b0, 1'b1, 5'd0);
        s_axis_tvalid = 1'b1;
        rstn = 1'b0;
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0;
        checkOutput("midrst_tready", s_axis_tready, 0);
        checkOutput("midrst_busy", check_busy, 0);
        checkOutput("midrst_pkt_cnt", pkt_cnt, 0);
        checkOutput("midrst_beat_cnt", beat_cnt, 0);
        checkOutput("midrst_pass", pass, 0);
        rstn = 1'b1;
        repeat (80) @(posedge clk);
        #1;
        checkOutput("midrst_no_done", done_count, done_before);
        checkOutput("midrst_idle", check_busy, 0);

        checkOutput("sb_drained", sb_q.size(), 0);
        checkOutput("done_total", done_count, runs_expected);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
